// File: rtl/serializer_word_scheduler_pkg.sv
// Shared definitions for the serializer word scheduler: link state encoding
// and the default training / idle words.
package serializer_word_scheduler_pkg;

    typedef enum logic [1:0] {
        LS_RST   = 2'd0,
        LS_TRAIN = 2'd1,
        LS_RUN   = 2'd2
    } link_state_t;

    localparam logic [7:0] DEF_TRAIN_WORD = 8'hF0;
    localparam logic [7:0] DEF_IDLE_WORD  = 8'hBC;

endpackage

// File: rtl/serializer_word_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N. gnt is one-hot (or zero when nothing requests).
module serializer_word_scheduler_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] idx;

    // Scan from ptr upward, first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        any     = |req;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/serializer_word_scheduler.sv
// Word-rate scheduler feeding the serializer din: training burst after reset
// or on request, then round-robin service of the requester word streams,
// idle filler when nobody is valid.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  LS_RST   | one quiet cycle after reset releases, serializer disabled
//  LS_TRAIN | TRAIN_WORD every cycle until the burst counter expires
//  LS_RUN   | arbitrated requester words, IDLE_WORD when nothing valid
module serializer_word_scheduler
    import serializer_word_scheduler_pkg::*;
#(
    parameter int                   WORDWIDTH   = 8,
    parameter int                   NREQ        = 4,
    parameter int                   TRAIN_WORDS = 64,
    parameter logic [WORDWIDTH-1:0] TRAIN_WORD  = WORDWIDTH'(DEF_TRAIN_WORD),
    parameter logic [WORDWIDTH-1:0] IDLE_WORD   = WORDWIDTH'(DEF_IDLE_WORD),
    localparam int                  GW          = $clog2(NREQ)
) (
    input  logic                      clk1280,
    input  logic                      reset,
    input  logic                      train_req,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WORDWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      ser_enable,
    output logic [WORDWIDTH-1:0]      ser_din,
    output logic [1:0]                link_state,
    output logic [GW-1:0]             grant_id,
    output logic [15:0]               word_count
);

    localparam int CW = $clog2(TRAIN_WORDS + 1);
    localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_WORDS - 1);
    localparam logic [GW-1:0] PTR_LAST   = GW'(NREQ - 1);

    link_state_t          state;
    logic [CW-1:0]        train_cnt;
    logic [GW-1:0]        rr_ptr;

    logic [NREQ-1:0]      arb_req;
    logic [NREQ-1:0]      arb_gnt;
    logic [GW-1:0]        arb_idx;
    logic                 arb_any;
    logic [WORDWIDTH-1:0] words [NREQ];

    // A retrain request blocks acceptance in the same cycle, so no word is lost.
    assign arb_req    = (state == LS_RUN && !train_req) ? req_valid : '0;
    assign req_ready  = arb_gnt;
    assign link_state = state;

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*WORDWIDTH +: WORDWIDTH];
    end

    serializer_word_scheduler_rr_arbiter #(
        .N  (NREQ),
        .IW (GW)
    ) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Link FSM with registered serializer outputs, burst counter and rr pointer.
    always_ff @(posedge clk1280) begin
        if (reset) begin
            state      <= LS_RST;
            ser_enable <= 1'b0;
            ser_din    <= '0;
            grant_id   <= '0;
            word_count <= '0;
            train_cnt  <= '0;
            rr_ptr     <= '0;
        end else begin
            case (state)
                LS_RST: begin
                    state      <= LS_TRAIN;
                    ser_enable <= 1'b1;
                    ser_din    <= TRAIN_WORD;
                    train_cnt  <= '0;
                end
                LS_TRAIN: begin
                    ser_enable <= 1'b1;
                    if (train_req) begin
                        train_cnt <= '0;
                        ser_din   <= TRAIN_WORD;
                    end else if (train_cnt == TRAIN_LAST) begin
                        state   <= LS_RUN;
                        ser_din <= IDLE_WORD;
                    end else begin
                        train_cnt <= train_cnt + 1'b1;
                        ser_din   <= TRAIN_WORD;
                    end
                end
                LS_RUN: begin
                    ser_enable <= 1'b1;
                    if (train_req) begin
                        state     <= LS_TRAIN;
                        train_cnt <= '0;
                        ser_din   <= TRAIN_WORD;
                    end else if (arb_any) begin
                        ser_din    <= words[arb_idx];
                        grant_id   <= arb_idx;
                        rr_ptr     <= (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
                        word_count <= word_count + 16'd1;
                    end else begin
                        ser_din <= IDLE_WORD;
                    end
                end
                default: begin
                    state      <= LS_RST;
                    ser_enable <= 1'b0;
                    ser_din    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_word_scheduler.sv
// Bench for serializer_word_scheduler: a cycle model pushes the expected
// req_ready and post-edge outputs per cycle; each scenario pops and compares.
module tb_serializer_word_scheduler;

    logic        clk1280 = 1'b0;
    logic        reset = 1'b1;
    logic        train_req = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        ser_enable;
    logic [7:0]  ser_din;
    logic [1:0]  link_state;
    logic [1:0]  grant_id;
    logic [15:0] word_count;

    always #5 clk1280 = ~clk1280;

    serializer_word_scheduler #(
        .WORDWIDTH   (8),
        .NREQ        (4),
        .TRAIN_WORDS (64),
        .TRAIN_WORD  (8'hF0),
        .IDLE_WORD   (8'hBC)
    ) dut (
        .clk1280    (clk1280),
        .reset      (reset),
        .train_req  (train_req),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .ser_enable (ser_enable),
        .ser_din    (ser_din),
        .link_state (link_state),
        .grant_id   (grant_id),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [3:0]  rdy;
        logic        en;
        logic [7:0]  din;
        logic [1:0]  ls;
        logic [1:0]  gid;
        logic [15:0] wc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] obs_rdy;

    int          m_state = 0;
    int          m_cnt = 0;
    int          m_ptr = 0;
    logic [1:0]  m_gid = '0;
    logic [15:0] m_wc = '0;
    logic [7:0]  m_din = '0;
    logic        m_en = 1'b0;

    // Drive one cycle, record req_ready, advance the model, push expectations.
    task automatic step(input logic r, input logic tr, input logic [3:0] v, input logic [31:0] d);
        exp_t x;
        int   g;
        int   c;
        reset = r; train_req = tr; req_valid = v; req_data = d;
        #1;
        obs_rdy = req_ready;
        x = '0;
        g = -1;
        if (m_state == 2 && !tr) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (g >= 0) x.rdy[g] = 1'b1;
        if (r) begin
            m_state = 0; m_cnt = 0; m_ptr = 0; m_gid = '0; m_wc = '0; m_din = '0; m_en = 1'b0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_cnt = 0; m_din = 8'hF0; m_en = 1'b1; end
                1: begin
                    if (tr) begin m_cnt = 0; m_din = 8'hF0; end
                    else if (m_cnt == 63) begin m_state = 2; m_din = 8'hBC; end
                    else begin m_cnt++; m_din = 8'hF0; end
                end
                default: begin
                    if (tr) begin m_state = 1; m_cnt = 0; m_din = 8'hF0; end
                    else if (g >= 0) begin
                        m_din = d[g*8 +: 8]; m_gid = 2'(g); m_ptr = (g + 1) % 4; m_wc = m_wc + 16'd1;
                    end else m_din = 8'hBC;
                end
            endcase
        end
        x.en = m_en; x.din = m_din; x.ls = 2'(m_state); x.gid = m_gid; x.wc = m_wc;
        sb.push_back(x);
        @(posedge clk1280);
        @(negedge clk1280);
    endtask

    task automatic test_reset();
        int n_train;
        step(1'b1, 1'b0, 4'h0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'h0, 32'h0);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL reset_hold: got %h expected %h", {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
        end
        n_cmp++;
        if (ser_din !== 8'h00 || link_state !== 2'd0 || ser_enable !== 1'b0) begin
            n_err++; $display("FAIL reset_values: din=%h ls=%0d en=%b required 00/0/0", ser_din, link_state, ser_enable);
        end
        n_train = 0;
        for (int i = 0; i < 70; i++) begin
            step(1'b0, 1'b0, 4'h0, 32'h0);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL reset_train cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
            if (link_state == 2'd1 && ser_din == 8'hF0) n_train++;
        end
        n_cmp++;
        if (n_train !== 64 || ser_din !== 8'hBC || link_state !== 2'd2) begin
            n_err++; $display("FAIL train_len: words=%0d din=%h ls=%0d required 64/bc/2", n_train, ser_din, link_state);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] wc0;
        wc0 = word_count;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 4'hF, 32'h13121110);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL round_robin cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
        end
        n_cmp++;
        if (word_count - wc0 !== 16'd12) begin
            n_err++; $display("FAIL rr_count: delta=%0d required 12", word_count - wc0);
        end
    endtask

    task automatic test_single();
        logic [15:0] wc0;
        wc0 = word_count;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, (i < 5) ? 4'b0100 : 4'b0000, 32'h005A0000);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL single cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
        end
        n_cmp++;
        if (word_count - wc0 !== 16'd5 || ser_din !== 8'hBC) begin
            n_err++; $display("FAIL single_count: delta=%0d din=%h required 5/bc", word_count - wc0, ser_din);
        end
    endtask

    task automatic test_retrain_pulse();
        for (int i = 0; i < 72; i++) begin
            step(1'b0, (i == 3), 4'b0010, 32'h00002100 | 32'(i));
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL retrain cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
            if (i == 3) begin
                n_cmp++;
                if (obs_rdy !== 4'b0000) begin
                    n_err++; $display("FAIL retrain_ready: got %b required 0000", obs_rdy);
                end
            end
        end
        n_cmp++;
        if (link_state !== 2'd2 || grant_id !== 2'd1) begin
            n_err++; $display("FAIL retrain_resume: ls=%0d gid=%0d required 2/1", link_state, grant_id);
        end
    endtask

    task automatic test_train_extend();
        int n_train;
        n_train = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, (i == 0 || i == 31), 4'h0, 32'h0);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL extend cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
            if (link_state == 2'd1 && ser_din == 8'hF0) n_train++;
        end
        n_cmp++;
        if (n_train !== 95) begin
            n_err++; $display("FAIL extend_len: words=%0d required 95", n_train);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'hF, 32'h44332211);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL midrun cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
        end
        step(1'b1, 1'b0, 4'hF, 32'h44332211);
        e = sb.pop_front(); n_cmp++;
        if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
            n_err++; $display("FAIL midrun_reset: got %h expected %h", {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
        end
        n_cmp++;
        if (ser_din !== 8'h00 || ser_enable !== 1'b0 || link_state !== 2'd0 || grant_id !== 2'd0 || word_count !== 16'h0) begin
            n_err++; $display("FAIL midrun_values: din=%h en=%b ls=%0d gid=%0d wc=%h required all zero", ser_din, ser_enable, link_state, grant_id, word_count);
        end
        for (int i = 0; i < 68; i++) begin
            step(1'b0, 1'b0, (i >= 65) ? 4'hF : 4'h0, 32'h44332211);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL midrun_after cyc %0d: got %h expected %h", i, {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
            if (i == 65) begin
                n_cmp++;
                if (grant_id !== 2'd0 || ser_din !== 8'h11) begin
                    n_err++; $display("FAIL ptr_reset: gid=%0d din=%h required 0/11", grant_id, ser_din);
                end
            end
        end
    endtask

    task automatic test_wrap();
        while (m_wc != 16'hFFFF) begin
            step(1'b0, 1'b0, 4'(($urandom % 15) + 1), $urandom);
            e = sb.pop_front(); n_cmp++;
            if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
                n_err++; $display("FAIL wrap_fill: got %h expected %h", {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
            end
        end
        n_cmp++;
        if (word_count !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_top: wc=%h required ffff", word_count);
        end
        step(1'b0, 1'b0, 4'b1000, 32'h77000000);
        e = sb.pop_front(); n_cmp++;
        if ({obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count} !== e) begin
            n_err++; $display("FAIL wrap_step: got %h expected %h", {obs_rdy, ser_enable, ser_din, link_state, grant_id, word_count}, e);
        end
        n_cmp++;
        if (word_count !== 16'h0000 || ser_din !== 8'h77) begin
            n_err++; $display("FAIL wrap_zero: wc=%h din=%h required 0000/77", word_count, ser_din);
        end
    endtask

    initial begin
        @(negedge clk1280);
        test_reset();
        test_round_robin();
        test_single();
        test_retrain_pulse();
        test_train_extend();
        test_reset_mid_run();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
